// File: rtl/key_sched_ctrl_if.sv
// Signal bundle between key_sched_ctrl and its host, key_cache and the external T' unit.
// slave = controller side, master = environment side.
interface key_sched_ctrl_if #(
  parameter int group_size_p   = 128,
  parameter int word_width_p   = 32,
  parameter int turn_key_num_p = 32
);
  localparam int idx_w_lp = $clog2(turn_key_num_p);

  logic [group_size_p-1:0] key_i;
  logic                    v_key_i;
  logic                    key_ready_o;
  logic                    flush_i;
  logic [group_size_p-1:0] cache_key_o;
  logic                    cache_v_key_o;
  logic                    cache_missed_i;
  logic [word_width_p-1:0] cache_w_o;
  logic [idx_w_lp-1:0]     cache_idx_w_o;
  logic                    cache_v_w_o;
  logic                    cache_invalid_o;
  logic [word_width_p-1:0] tp_x_o;
  logic [word_width_p-1:0] tp_t_i;
  logic                    done_o;
  logic                    hit_o;

  modport slave (
    input  key_i, v_key_i, flush_i, cache_missed_i, tp_t_i,
    output key_ready_o, cache_key_o, cache_v_key_o, cache_w_o, cache_idx_w_o,
           cache_v_w_o, cache_invalid_o, tp_x_o, done_o, hit_o
  );

  modport master (
    output key_i, v_key_i, flush_i, cache_missed_i, tp_t_i,
    input  key_ready_o, cache_key_o, cache_v_key_o, cache_w_o, cache_idx_w_o,
           cache_v_w_o, cache_invalid_o, tp_x_o, done_o, hit_o
  );
endinterface

// File: rtl/key_sched_ctrl.sv
// SM4 round-key cache controller: CAM lookup on accept, one-round-key-per-cycle expansion on miss.
// Optional saturating hit/miss counters are enabled by defining KEY_SCHED_PERF_CNT_EN.
module key_sched_ctrl #(
  parameter int group_size_p   = 128,
  parameter int word_width_p   = 32,
  parameter int turn_key_num_p = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  key_sched_ctrl_if.slave  bus
`ifdef KEY_SCHED_PERF_CNT_EN
  ,
  output logic [15:0]      hit_cnt_o,
  output logic [15:0]      miss_cnt_o
`endif
);
  localparam int idx_w_lp = $clog2(turn_key_num_p);
  localparam logic [group_size_p-1:0] fk_lp = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;
  localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(turn_key_num_p - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e                  state_r;
  state_e                  fsm_nxt_s;
  state_e                  state_nxt_s;
  logic [idx_w_lp-1:0]     cnt_r;
  logic [word_width_p-1:0] k0_r, k1_r, k2_r, k3_r;
  logic                    hit_r;

  logic                    accept_s;
  logic [word_width_p-1:0] rk_s;
  logic                    key_ready_s;
  logic [group_size_p-1:0] cache_key_s;
  logic                    cache_v_key_s;
  logic [word_width_p-1:0] cache_w_s;
  logic [idx_w_lp-1:0]     cache_idx_s;
  logic                    cache_v_w_s;
  logic [word_width_p-1:0] tp_x_s;
  logic                    done_s;
  logic                    hit_s;

  // CK byte j (MSB first) of round i is (4i+j)*7 in 8-bit arithmetic.
  function automatic logic [word_width_p-1:0] ck_word(input logic [idx_w_lp-1:0] i);
    logic [word_width_p-1:0] w;
    logic [7:0]              base;
    w    = '0;
    base = 8'(i) << 2;
    for (int j = 0; j < 4; j++) begin
      w[word_width_p-1-8*j -: 8] = (base + 8'(j)) * 8'd7;
    end
    return w;
  endfunction

  assign rk_s = k0_r ^ bus.tp_t_i;

  // Next-state and combinational handshake/cache outputs.
  always_comb begin
    fsm_nxt_s     = state_r;
    accept_s      = 1'b0;
    key_ready_s   = 1'b0;
    cache_key_s   = '0;
    cache_v_key_s = 1'b0;
    cache_w_s     = '0;
    cache_idx_s   = '0;
    cache_v_w_s   = 1'b0;
    tp_x_s        = '0;
    done_s        = 1'b0;
    hit_s         = 1'b0;
    case (state_r)
      IDLE: begin
        key_ready_s = ~bus.flush_i;
        if (bus.v_key_i && !bus.flush_i) begin
          accept_s      = 1'b1;
          cache_v_key_s = 1'b1;
          cache_key_s   = bus.key_i;
          fsm_nxt_s     = bus.cache_missed_i ? EXPAND : DONE;
        end else begin
          fsm_nxt_s = IDLE;
        end
      end
      EXPAND: begin
        tp_x_s      = k1_r ^ k2_r ^ k3_r ^ ck_word(cnt_r);
        cache_v_w_s = 1'b1;
        cache_idx_s = cnt_r;
        cache_w_s   = rk_s;
        if (cnt_r == last_idx_lp) begin
          fsm_nxt_s = DONE;
        end else begin
          fsm_nxt_s = EXPAND;
        end
      end
      DONE: begin
        done_s    = 1'b1;
        hit_s     = hit_r;
        fsm_nxt_s = IDLE;
      end
      default: begin
        fsm_nxt_s = IDLE;
      end
    endcase
    // A flush aborts whatever is in flight; the current cycle's write still goes out.
    state_nxt_s = bus.flush_i ? IDLE : fsm_nxt_s;
  end

  // State, round counter and key-schedule shift register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      k0_r    <= '0;
      k1_r    <= '0;
      k2_r    <= '0;
      k3_r    <= '0;
      hit_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (bus.flush_i) begin
        cnt_r <= '0;
      end else if (accept_s) begin
        cnt_r <= '0;
        hit_r <= ~bus.cache_missed_i;
        if (bus.cache_missed_i) begin
          {k0_r, k1_r, k2_r, k3_r} <= bus.key_i ^ fk_lp;
        end
      end else if (state_r == EXPAND) begin
        {k0_r, k1_r, k2_r, k3_r} <= {k1_r, k2_r, k3_r, rk_s};
        cnt_r <= cnt_r + idx_w_lp'(1);
      end
    end
  end

  assign bus.key_ready_o     = key_ready_s;
  assign bus.cache_key_o     = cache_key_s;
  assign bus.cache_v_key_o   = cache_v_key_s;
  assign bus.cache_w_o       = cache_w_s;
  assign bus.cache_idx_w_o   = cache_idx_s;
  assign bus.cache_v_w_o     = cache_v_w_s;
  assign bus.cache_invalid_o = bus.flush_i;
  assign bus.tp_x_o          = tp_x_s;
  assign bus.done_o          = done_s;
  assign bus.hit_o           = hit_s;

`ifdef KEY_SCHED_PERF_CNT_EN
  logic [15:0] hit_cnt_r;
  logic [15:0] miss_cnt_r;

  // Saturating lookup statistics; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hit_cnt_r  <= 16'h0000;
      miss_cnt_r <= 16'h0000;
    end else if (accept_s) begin
      if (bus.cache_missed_i) begin
        if (miss_cnt_r != 16'hFFFF) begin
          miss_cnt_r <= miss_cnt_r + 16'h0001;
        end
      end else begin
        if (hit_cnt_r != 16'hFFFF) begin
          hit_cnt_r <= hit_cnt_r + 16'h0001;
        end
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_r;
  assign miss_cnt_o = miss_cnt_r;
`endif
endmodule
